// File: rtl/palindrome_scan_seq.sv
// Multi-cycle bit-palindrome checker. It compares PAIRS_PER_CYCLE mirrored bit pairs per cycle
// and stops at the first mismatch. Words come in and results go out over valid/ready handshakes.
module palindrome_scan_seq #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned PAIRS_PER_CYCLE = 1,
  parameter int unsigned LW              = $clog2(WIDTH + 1),
  parameter int unsigned IW              = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pal,
  output logic [LW-1:0]    out_len,
  output logic [IW-1:0]    out_mis_idx
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    lo_q, lo_d, hi_q, hi_d, mis_q, mis_d;
  logic [LW-1:0]    len_q, len_d;
  logic             pal_q, pal_d;
  logic [IW-1:0]    msb;
  logic             nonzero;

  // Highest set bit of the incoming word. It sets the mode-1 key in the accept cycle.
  always_comb begin
    msb = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_data[i]) msb = IW'(i);
    end
  end

  assign nonzero = |in_data;

  always_comb begin
    int  lj, hj, lo_n, hi_n;
    logic miss;
    st_d   = st_q;
    data_d = data_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    mis_d  = mis_q;
    len_d  = len_q;
    pal_d  = pal_q;
    miss   = 1'b0;
    lj     = 0;
    hj     = 0;
    lo_n   = int'(lo_q) + int'(PAIRS_PER_CYCLE);
    hi_n   = int'(hi_q) - int'(PAIRS_PER_CYCLE);

    case (st_q)
      StIdle: begin
        if (in_valid) begin
          data_d = in_data;
          lo_d   = '0;
          mis_d  = '0;
          if (!in_mode) begin
            hi_d  = IW'(WIDTH - 1);
            len_d = LW'(WIDTH);
          end else if (nonzero) begin
            hi_d  = msb;
            len_d = LW'(msb) + LW'(1);
          end else begin
            hi_d  = '0;
            len_d = '0;
          end
          if (len_d <= LW'(1)) begin
            pal_d = 1'b1;
            st_d  = StDone;
          end else begin
            pal_d = 1'b0;
            st_d  = StScan;
          end
        end
      end

      StScan: begin
        // Signed ints keep hi-j from wrapping; pairs at or past the middle are skipped.
        for (int j = 0; j < int'(PAIRS_PER_CYCLE); j++) begin
          lj = int'(lo_q) + j;
          hj = int'(hi_q) - j;
          if (!miss && (lj < hj) && (data_q[IW'(lj)] != data_q[IW'(hj)])) begin
            miss  = 1'b1;
            mis_d = IW'(lj);
          end
        end
        if (miss) begin
          pal_d = 1'b0;
          st_d  = StDone;
        end else if (lo_n >= hi_n) begin
          pal_d = 1'b1;
          mis_d = '0;
          st_d  = StDone;
        end else begin
          lo_d = IW'(lo_n);
          hi_d = IW'(hi_n);
        end
      end

      StDone: begin
        if (out_ready) st_d = StIdle;
      end

      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      data_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      mis_q  <= '0;
      len_q  <= '0;
      pal_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      mis_q  <= mis_d;
      len_q  <= len_d;
      pal_q  <= pal_d;
    end
  end

  assign in_ready    = (st_q == StIdle);
  assign out_valid   = (st_q == StDone);
  assign out_pal     = pal_q;
  assign out_len     = len_q;
  assign out_mis_idx = mis_q;

endmodule
